// File: rtl/logic_unit_pkg.sv
// Shared opcode encodings and the bitwise operation helper for logic_unit_acc.
package logic_unit_pkg;

    localparam int OP_W  = 3;
    localparam int MAX_W = 32;

    localparam logic [OP_W-1:0] OP_AND   = 3'b000;
    localparam logic [OP_W-1:0] OP_OR    = 3'b001;
    localparam logic [OP_W-1:0] OP_NOTA  = 3'b010;
    localparam logic [OP_W-1:0] OP_XOR   = 3'b011;
    localparam logic [OP_W-1:0] OP_NAND  = 3'b100;
    localparam logic [OP_W-1:0] OP_NOR   = 3'b101;
    localparam logic [OP_W-1:0] OP_XNOR  = 3'b110;
    localparam logic [OP_W-1:0] OP_PASSA = 3'b111;

    // Operates at the widest supported width; callers truncate to their own
    // WIDTH, so inverted upper bits of zero-extended operands are harmless.
    function automatic logic [MAX_W-1:0] op_apply(
        input logic [OP_W-1:0]  op,
        input logic [MAX_W-1:0] x,
        input logic [MAX_W-1:0] y
    );
        logic [MAX_W-1:0] r;
        case (op)
            OP_AND:   r = x & y;
            OP_OR:    r = x | y;
            OP_NOTA:  r = ~x;
            OP_XOR:   r = x ^ y;
            OP_NAND:  r = ~(x & y);
            OP_NOR:   r = ~(x | y);
            OP_XNOR:  r = ~(x ^ y);
            default:  r = x;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/logic_fifo2.sv
// Two-entry FIFO. Entry 0 is always the head; the head output reads zero
// while the FIFO is empty so downstream flags never show stale data.
module logic_fifo2 #(
    parameter int DW = 10
) (
    input  logic          iClk,
    input  logic          iRst,
    input  logic          iPush,
    input  logic          iPop,
    input  logic [DW-1:0] iData,
    output logic [DW-1:0] oData,
    output logic [1:0]    oOcc
);
    import logic_unit_pkg::*;

    logic [DW-1:0] mem0;
    logic [DW-1:0] mem1;
    logic [1:0]    occ;
    logic          doPush;
    logic          doPop;

    // A full FIFO refuses pushes and an empty one refuses pops.
    always_comb begin
        doPush = iPush && (occ != 2'd2);
        doPop  = iPop  && (occ != 2'd0);
    end

    // Storage and occupancy update; a pop at occupancy 2 shifts entry 1 forward.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            mem0 <= '0;
            mem1 <= '0;
            occ  <= 2'd0;
        end else begin
            case ({doPush, doPop})
                2'b10: begin
                    if (occ == 2'd0) mem0 <= iData;
                    else             mem1 <= iData;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    mem0 <= mem1;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    // only reachable at occupancy 1: the new beat replaces the head
                    mem0 <= iData;
                end
                default: ;
            endcase
        end
    end

    // Head presentation, forced to zero when empty.
    always_comb begin
        oData = (occ != 2'd0) ? mem0 : '0;
        oOcc  = occ;
    end

endmodule

// File: rtl/logic_unit_acc.sv
// Registered bitwise logic unit with optional accumulate fold, a 2-entry
// output buffer and a delivered-result counter.
module logic_unit_acc #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iValid,
    output logic             oReady,
    input  logic [WIDTH-1:0] iA,
    input  logic [WIDTH-1:0] iB,
    input  logic [2:0]       iOp,
    input  logic             iAcc,
    input  logic             iFirst,
    output logic             oValid,
    input  logic             iReady,
    output logic [WIDTH-1:0] oResult,
    output logic             oZero,
    output logic             oParity,
    output logic [CNT_W-1:0] oCount
);
    import logic_unit_pkg::*;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] opX;
    logic [WIDTH-1:0] opY;
    logic [WIDTH-1:0] res;
    logic             accept;
    logic             deliver;
    logic [WIDTH+1:0] pushData;
    logic [WIDTH+1:0] headData;
    logic [1:0]       occ;
    logic [CNT_W-1:0] count;

    // Operand mux: in accumulate mode the accumulator takes the first-operand
    // slot and iA moves to the second, so NOT/PASS act on acc.
    always_comb begin
        opX = iAcc ? acc : iA;
        opY = iAcc ? iA  : iB;
        if (iAcc && iFirst) res = iA;
        else                res = WIDTH'(op_apply(iOp, MAX_W'(opX), MAX_W'(opY)));
        pushData = {^res, (res == '0), res};
    end

    // Handshakes; oReady depends only on registered occupancy and reset.
    always_comb begin
        oReady  = (occ != 2'd2) && !iRst;
        oValid  = (occ != 2'd0);
        accept  = iValid && oReady;
        deliver = oValid && iReady;
    end

    // Accumulator follows every accepted accumulate beat.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)                acc <= '0;
        else if (accept && iAcc) acc <= res;
    end

    // Delivered-result counter, wrapping naturally.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst)         count <= '0;
        else if (deliver) count <= count + CNT_W'(1);
    end

    logic_fifo2 #(.DW(WIDTH + 2)) uFifo (
        .iClk  (iClk),
        .iRst  (iRst),
        .iPush (accept),
        .iPop  (deliver),
        .iData (pushData),
        .oData (headData),
        .oOcc  (occ)
    );

    // Head fields fan out to the result ports.
    always_comb begin
        oResult = headData[WIDTH-1:0];
        oZero   = headData[WIDTH];
        oParity = headData[WIDTH+1];
        oCount  = count;
    end

endmodule
